// File: rtl/dff_pkg.sv
// Shared types and helpers for the dff_pipe register pipeline.
package dff_pkg;

  typedef struct packed {
    logic rst;
    logic flush;
    logic en;
  } stage_ctl_t;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Data/control bundle for dff_pipe; the occ signal exists only with DFF_PIPE_OCC_EN.
interface dff_pipe_if
  import dff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic             en;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
`ifdef DFF_PIPE_OCC_EN
  localparam int OW = clog2p1(DEPTH);
  logic [OW-1:0]    occ;
`endif

  modport master (
    output en, flush, d, d_valid,
    input  q, q_valid
`ifdef DFF_PIPE_OCC_EN
    , input occ
`endif
  );

  modport slave (
    input  en, flush, d, d_valid,
    output q, q_valid
`ifdef DFF_PIPE_OCC_EN
    , output occ
`endif
  );
endinterface

// File: rtl/dff_stage.sv
// One pipeline stage: WIDTH-bit data register plus valid bit, priority rst > flush > en > hold.
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  stage_ctl_t       ctl_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] q_o,
  output logic             vld_o
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             v_q, v_d;

  // Data loads regardless of valid; the valid bit only ever comes from vld_i.
  always_comb begin
    q_d = q_q;
    v_d = v_q;
    if (ctl_i.rst || ctl_i.flush) begin
      q_d = RST_VAL;
      v_d = 1'b0;
    end else if (ctl_i.en) begin
      q_d = d_i;
      v_d = vld_i;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
    v_q <= v_d;
  end

  assign q_o   = q_q;
  assign vld_o = v_q;
endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage retiming pipeline with stall and flush; DFF_PIPE_OCC_EN adds the occ counter.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic        clk,
  input  logic        rst,
  dff_pipe_if.slave   bus
);
  if (DEPTH < 1) begin : g_bad_depth
    $error("dff_pipe: DEPTH must be >= 1");
  end

  stage_ctl_t                   ctl;
  logic [DEPTH-1:0][WIDTH-1:0]  data;
  logic [DEPTH-1:0]             vld;

  assign ctl = '{rst: rst, flush: bus.flush, en: bus.en};

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] din;
    logic             vin;
    if (i == 0) begin : g_head
      assign din = bus.d;
      assign vin = bus.d_valid;
    end else begin : g_body
      assign din = data[i-1];
      assign vin = vld[i-1];
    end

    dff_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
      .clk   (clk),
      .ctl_i (ctl),
      .d_i   (din),
      .vld_i (vin),
      .q_o   (data[i]),
      .vld_o (vld[i])
    );
  end

  assign bus.q       = data[DEPTH-1];
  assign bus.q_valid = vld[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
  localparam int OW = clog2p1(DEPTH);
  logic [OW-1:0] occ_q, occ_d;

  // Entering and leaving words on the same advancing edge cancel out.
  always_comb begin
    occ_d = occ_q;
    if (rst || bus.flush)
      occ_d = '0;
    else if (bus.en)
      occ_d = occ_q + OW'(bus.d_valid) - OW'(vld[DEPTH-1]);
  end

  always_ff @(posedge clk) begin
    occ_q <= occ_d;
  end

  assign bus.occ = occ_q;

  always @(posedge clk) begin
    if (!rst) begin
      assert (occ_q <= OW'(DEPTH)) else $error("dff_pipe: occ above DEPTH");
      assert (occ_q == OW'($countones(vld))) else $error("dff_pipe: occ differs from valid count");
    end
  end
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe (DEPTH=4 and DEPTH=1 instances) with a queue scoreboard.
module tb_dff_pipe;
  localparam int          W  = 8;
  localparam int          DP = 4;
  localparam logic [W-1:0] RV = 8'hA5;

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
  } ent_t;

  logic clk, rst;
  int   n_chk, n_fail;
  ent_t sb[$];
  logic d1, exp1_q, exp1_v;
  logic seen_ff;
  int   occ_max;

  dff_pipe_if #(.WIDTH(W), .DEPTH(DP)) bus  ();
  dff_pipe_if #(.WIDTH(1), .DEPTH(1))  bus1 ();

  dff_pipe #(.WIDTH(W), .DEPTH(DP), .RST_VAL(RV)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  dff_pipe #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare both DUTs against the scoreboard just after an edge.
  task automatic check();
    logic         ev;
    logic [W-1:0] eq;
    int           cnt;
    ev  = (sb.size() == DP) ? sb[0].v : 1'b0;
    eq  = (sb.size() == DP) ? sb[0].d : RV;
    cnt = 0;
    foreach (sb[i]) if (sb[i].v) cnt++;
    chk("q_valid", {31'd0, bus.q_valid}, {31'd0, ev});
    if (ev || sb.size() < DP) chk("q", {24'd0, bus.q}, {24'd0, eq});
    if (bus.q_valid && bus.q == 8'hFF) seen_ff = 1'b1;
`ifdef DFF_PIPE_OCC_EN
    chk("occ", {29'd0, bus.occ}, cnt);
    if (int'(bus.occ) > occ_max) occ_max = int'(bus.occ);
    chk("occ1", {31'd0, bus1.occ}, {31'd0, exp1_v});
`endif
    chk("d1_q", {31'd0, bus1.q}, {31'd0, exp1_q});
    chk("d1_qv", {31'd0, bus1.q_valid}, {31'd0, exp1_v});
  endtask

  task automatic step(input logic e, input logic f, input logic v, input logic [W-1:0] dd);
    bus.en      = e;
    bus.flush   = f;
    bus.d_valid = v;
    bus.d       = dd;
    bus1.d      = d1;
    @(posedge clk);
    if (rst || f) begin
      sb.delete();
    end else if (e) begin
      sb.push_back('{v: v, d: dd});
      if (sb.size() > DP) void'(sb.pop_front());
    end
    exp1_q = rst ? 1'b0 : d1;
    exp1_v = !rst;
    d1     = ~d1;
    #1 check();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; seen_ff = 1'b0; occ_max = 0;
    d1 = 1'b0; exp1_q = 1'b0; exp1_v = 1'b0;
    rst = 1'b1;
    bus.en = 1'b0; bus.flush = 1'b0; bus.d_valid = 1'b0; bus.d = '0;
    bus1.en = 1'b1; bus1.flush = 1'b0; bus1.d_valid = 1'b1; bus1.d = 1'b0;
    #2;

    // Reset held two cycles
    step(1'b1, 1'b0, 1'b1, 8'h77);
    step(1'b1, 1'b0, 1'b1, 8'h77);
    chk("rst_q", {24'd0, bus.q}, {24'd0, RV});
    chk("rst_qv", {31'd0, bus.q_valid}, 32'd0);
    rst = 1'b0;

    // Latency: four words back to back
    step(1'b1, 1'b0, 1'b1, 8'h01);
    step(1'b1, 1'b0, 1'b1, 8'h02);
    step(1'b1, 1'b0, 1'b1, 8'h03);
    chk("lat_early", {31'd0, bus.q_valid}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 8'h04);
    chk("lat_first", {24'd0, bus.q}, 32'h01);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h00);

    // Stall with two words in flight
    step(1'b1, 1'b0, 1'b1, 8'h21);
    step(1'b1, 1'b0, 1'b1, 8'h22);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'hEE);
    chk("stall_qv", {31'd0, bus.q_valid}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("stall_out", {24'd0, bus.q}, 32'h21);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("stall_out2", {24'd0, bus.q}, 32'h22);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00);

    // Bubbles
    occ_max = 0;
    step(1'b1, 1'b0, 1'b1, 8'h10);
    step(1'b1, 1'b0, 1'b0, 8'h11);
    step(1'b1, 1'b0, 1'b1, 8'h12);
    step(1'b1, 1'b0, 1'b0, 8'h13);
    chk("bub_q0", {24'd0, bus.q}, 32'h10);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("bub_qv1", {31'd0, bus.q_valid}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("bub_q2", {24'd0, bus.q}, 32'h12);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
`ifdef DFF_PIPE_OCC_EN
    chk("bub_occ_max", occ_max, 2);
`endif

    // Flush with simultaneous valid input
    step(1'b1, 1'b0, 1'b1, 8'h31);
    step(1'b1, 1'b0, 1'b1, 8'h32);
    step(1'b1, 1'b0, 1'b1, 8'h33);
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    chk("fl_q", {24'd0, bus.q}, {24'd0, RV});
    step(1'b1, 1'b0, 1'b1, 8'h44);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("fl_accept", {24'd0, bus.q}, 32'h44);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("fl_no_ff", {31'd0, seen_ff}, 32'd0);

    // Unknown data with d_valid=0 must stay a bubble
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 8'hxx);
    step(1'b1, 1'b0, 1'b1, 8'h55);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00);

    // Reset mid-stream
    step(1'b1, 1'b0, 1'b1, 8'h61);
    step(1'b1, 1'b0, 1'b1, 8'h62);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 8'h63);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
